// File: rtl/vedic_seq_divider_if.sv
// Start/busy/done handshake and operand/result bundle
// for the iterative restoring divider.
interface vedic_seq_divider_if #(
   parameter int WIDTH = 6
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start,
      output dividend,
      output divisor,
      input  busy,
      input  done,
      input  quotient,
      input  remainder,
      input  div_by_zero
   );

   modport slave (
      input  start,
      input  dividend,
      input  divisor,
      output busy,
      output done,
      output quotient,
      output remainder,
      output div_by_zero
   );
endinterface

// File: rtl/vedic_seq_divider.sv
// Radix-2 restoring unsigned divider, one quotient bit
// per clock, start/busy/done handshake.
module vedic_seq_divider #(
   parameter int WIDTH = 6,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input logic                 clk,
   input logic                 rst_n,
   vedic_seq_divider_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE,
      RUN,
      ZERO
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic [CW-1:0]    cnt;

   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] quot_q;
   logic [WIDTH-1:0] rem_q;
   logic             dz_q;

   logic [WIDTH:0]   rs;
   logic [WIDTH:0]   tr;
   logic             fit;
   logic [WIDTH-1:0] r_nx;
   logic [WIDTH-1:0] q_nx;

   // r < d always holds, so the shifted remainder needs
   // only one extra bit and the trial sign is tr[WIDTH]
   always_comb begin
      rs   = {r, q[WIDTH-1]};
      tr   = rs - {1'b0, d};
      fit  = ~tr[WIDTH];
      r_nx = fit ? tr[WIDTH-1:0] : rs[WIDTH-1:0];
      q_nx = {q[WIDTH-2:0], fit};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         d      <= '0;
         q      <= '0;
         r      <= '0;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         quot_q <= '0;
         rem_q  <= '0;
         dz_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  d      <= bus.divisor;
                  q      <= bus.dividend;
                  r      <= '0;
                  busy_q <= 1'b1;
                  if (bus.divisor == '0) begin
                     state <= ZERO;
                  end else begin
                     cnt   <= CW'(WIDTH);
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               r   <= r_nx;
               q   <= q_nx;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  quot_q <= q_nx;
                  rem_q  <= r_nx;
                  dz_q   <= 1'b0;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            ZERO: begin
               quot_q <= '1;
               rem_q  <= q;
               dz_q   <= 1'b1;
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quot_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dz_q;
endmodule
